// File: rtl/capture_buffer_ctrl.sv
// Triggered burst capture of ADC samples into on-chip RAM with running sum and exposure count.
// Optional macro CUMSUM_SAT_EN: cumsum saturates and sum_sat flags it; otherwise cumsum wraps.
module capture_buffer_ctrl #(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned SUM_W  = 28,
   parameter int unsigned TIME_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_valid,
   input  logic [DATA_W-1:0]        sample_data,
   input  logic                     trig_in,
   input  logic                     arm,
   input  logic                     mode,
   input  logic [DATA_W-1:0]        threshold,
   input  logic [$clog2(DEPTH):0]   num_samples,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [31:0]              rd_data,
   output logic [$clog2(DEPTH):0]   samples_cnt,
   output logic [SUM_W-1:0]         cumsum,
   output logic [TIME_W-1:0]        exptime,
   output logic                     busy,
   output logic                     done,
   output logic                     sum_sat
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                trig_q;
   logic                trig_seen_q, trig_seen_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   thr_q, thr_d;
   logic [CW-1:0]       target_q, target_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [TIME_W-1:0]   exp_q, exp_d;
   logic                sat_q, sat_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [31:0]         rd_data_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                edge_c;
   logic                fire_c;
   logic [CW-1:0]       cnt_inc_c;
   logic [SUM_W-1:0]    acc_c;
   logic                acc_ovf_c;
   logic                wr_en_c;
   logic [AW-1:0]       wr_addr_c;

   assign edge_c    = trig_in & ~trig_q;
   assign fire_c    = mode_q ? (sample_data >= thr_q) : (trig_seen_q | edge_c);
   assign cnt_inc_c = cnt_q + CW'(1);

   // Running-sum adder: saturating or wrapping depending on build
`ifdef CUMSUM_SAT_EN
   logic [SUM_W:0] acc_ext_c;
   always_comb begin
      acc_ext_c = {1'b0, sum_q} + (SUM_W+1)'(sample_data);
      acc_ovf_c = acc_ext_c[SUM_W];
      acc_c     = acc_ovf_c ? {SUM_W{1'b1}} : acc_ext_c[SUM_W-1:0];
   end
`else
   always_comb begin
      acc_c     = sum_q + SUM_W'(sample_data);
      acc_ovf_c = 1'b0;
   end
`endif

   // Next-state and result logic; arm overrides everything else
   always_comb begin
      state_d     = state_q;
      trig_seen_d = trig_seen_q;
      mode_d      = mode_q;
      thr_d       = thr_q;
      target_d    = target_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      exp_d       = exp_q;
      sat_d       = sat_q;
      wr_en_c     = 1'b0;
      wr_addr_c   = cnt_q[AW-1:0];

      if (arm) begin
         state_d     = ARMED;
         trig_seen_d = 1'b0;
         mode_d      = mode;
         thr_d       = threshold;
         target_d    = ((num_samples == '0) || (num_samples > DEPTH_C)) ? DEPTH_C : num_samples;
         cnt_d       = '0;
         sum_d       = '0;
         exp_d       = '0;
         sat_d       = 1'b0;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (edge_c) begin
                  trig_seen_d = 1'b1;
               end
               if (sample_valid && fire_c) begin
                  wr_en_c   = 1'b1;
                  wr_addr_c = '0;
                  cnt_d     = CW'(1);
                  sum_d     = SUM_W'(sample_data);
                  state_d   = (target_q == CW'(1)) ? DONE : CAPTURE;
               end
            end
            CAPTURE: begin
               exp_d = (exp_q == {TIME_W{1'b1}}) ? exp_q : exp_q + TIME_W'(1);
               if (sample_valid) begin
                  wr_en_c = 1'b1;
                  cnt_d   = cnt_inc_c;
                  sum_d   = acc_c;
                  sat_d   = sat_q | acc_ovf_c;
                  if (cnt_inc_c == target_q) begin
                     state_d = DONE;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == ARMED) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         trig_q      <= 1'b0;
         trig_seen_q <= 1'b0;
         mode_q      <= 1'b0;
         thr_q       <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         exp_q       <= '0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_in;
         trig_seen_q <= trig_seen_d;
         mode_q      <= mode_d;
         thr_q       <= thr_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         exp_q       <= exp_d;
         sat_q       <= sat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_data_q   <= 32'(mem_q[rd_ptr]);
      end
   end

   // Sample RAM: no reset, read-before-write through the registered read port
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_addr_c] <= sample_data;
      end
   end

   assign rd_data     = rd_data_q;
   assign samples_cnt = cnt_q;
   assign cumsum      = sum_q;
   assign exptime     = exp_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sum_sat     = sat_q;

endmodule

// File: doc/capture_buffer_ctrl.md
# capture_buffer_ctrl

Parametrised acquisition front-end for the cytometer fabric: captures a triggered burst of ADC samples into on-chip RAM while accumulating a running sum and an exposure-time count. Sits between the sample source and the HPS PIO bank. The HPS arms it, polls `done`, then drains the buffer through a read pointer and a read-data port. It generalises the fixed 9-bit pointer / 28-bit sum / external-trigger arrangement:

- configurable width and depth;
- selectable external or threshold trigger;
- programmable burst length.

## Interface
Parameters:
- `DATA_W`, 14, sample width (1..32)
- `DEPTH`, 512, buffer depth in samples; power of two; `AW = log2(DEPTH)`
- `SUM_W`, 28, cumulative-sum width (must be ≥ `DATA_W`)
- `TIME_W`, 32, exposure-counter width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sample_valid`  in  1  qualifies `sample_data` this cycle
- `sample_data`  in  `DATA_W`  unsigned ADC sample
- `trig_in`  in  1  external trigger, synchronous; rising edge used
- `arm`  in  1  one-cycle pulse; clears results and arms a capture
- `mode`  in  1  0 = external trigger, 1 = threshold trigger; sampled on `arm`
- `threshold`  in  `DATA_W`  threshold level; sampled on `arm`
- `num_samples`  in  `AW+1`  burst length; sampled on `arm`
- `rd_ptr`  in  `AW`  HPS read address
- `rd_data`  out  32  buffer word at `rd_ptr`, zero-extended
- `samples_cnt`  out  `AW+1`  samples written in current/last burst
- `cumsum`  out  `SUM_W`  sum of captured samples
- `exptime`  out  `TIME_W`  clocks from first captured sample to completion
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `sum_sat`  out  1  cumsum saturated (see Configuration)

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- `arm` in any state:
  - go to ARMED;
  - clear `samples_cnt`, `cumsum`, `exptime`, `sum_sat`, `trig_seen`;
  - latch `mode`, `threshold`, target.
  - Target = `num_samples`, except 0 or > `DEPTH` → `DEPTH`.
  - `arm` during CAPTURE aborts the burst; buffer contents are undefined beyond the new count.
- ARMED:
  - `trig_seen` sets on `trig_in & ~trig_q`, where `trig_q` is `trig_in` registered.
  - Trigger condition, evaluated only on a `sample_valid` cycle:
    - mode 0: `trig_seen` or an edge in the same cycle;
    - mode 1: `sample_data >= threshold`.
  - On trigger:
    - write the sample to address 0;
    - `samples_cnt` = 1, `cumsum` = sample;
    - go to CAPTURE, or to DONE if target = 1.
- CAPTURE:
  - Each `sample_valid`: write to address `samples_cnt[AW-1:0]`, increment `samples_cnt`, `cumsum += sample`.
  - When the incremented count equals target, go to DONE in the same transition.
  - Trigger inputs are ignored.
- DONE: holds all results until the next `arm`.
- IDLE is reached only from reset.
- `exptime` increments by 1 every clock in CAPTURE and saturates at all-ones. The final value is the count of clocks from the first sample's cycle to the last sample's cycle, exclusive of the first.
- Reading:
  - permitted in every state;
  - same-address read/write in one cycle returns the old word (read-before-write);
  - buffer RAM is not cleared by reset.

## Timing
- Reset values: state IDLE; `rd_data`, `samples_cnt`, `cumsum`, `exptime`, `busy`, `done`, `sum_sat`, `trig_seen`, `trig_q` all 0.
- `rd_data` is registered, so data for `rd_ptr` presented at cycle N is valid at N+1.
- Result outputs (`samples_cnt`, `cumsum`, `exptime`, `done`, `busy`) are registered and update the cycle after the causing input.
- `done` rises in the clock after the last sample's `sample_valid` cycle; its final `cumsum`/`samples_cnt` are valid that same cycle.
- Back-to-back `sample_valid` is sustained at one sample per clock; there is no backpressure.
- `reset` asserted mid-burst forces IDLE immediately (asynchronously); partial results are lost.

## Configuration
- `CUMSUM_SAT_EN`:
  - When defined, `cumsum` saturates at 2^SUM_W−1 and `sum_sat` sets, staying set until `arm` or reset.
  - When undefined, `cumsum` wraps modulo 2^SUM_W and `sum_sat` is tied to 0.

## Test plan
- Ext mode, target 4, `sample_valid` every clock with data 10,20,30,40,50, edge coincident with sample 10 → buffer 0..3 = 10,20,30,40; `cumsum` 100; `samples_cnt` 4; `exptime` 3; `done` 1.
- Threshold mode, threshold 500, data ramp 0,100,…,900 one per clock, target 3 → captures 500,600,700; `cumsum` 1800.
- `num_samples` 0 with `DEPTH` 512 → 512 samples captured; `samples_cnt` 512; write address wraps to exactly 511 last.
- `SUM_W` = `DATA_W` = 8, data 200,200 → without macro: `cumsum` 144, `sum_sat` 0; with `CUMSUM_SAT_EN`: `cumsum` 255, `sum_sat` 1.
- `arm` mid-burst after 2 of 8 samples, then new trigger → counters restart at 0; `done` only after 8 new samples.
- `reset` pulse during CAPTURE → all outputs 0 within the same cycle; `rd_ptr` 0 after reset returns pre-reset RAM word one cycle later.
